// File: rtl/vga_text_buffer.sv
// Terminal-style character buffer: ROWS x COLS cells of {bg, fg, ascii} with a
// registered read port, a put-char cursor port, hardware scroll and screen clear.
module vga_text_buffer #(
    parameter int ROWS = 30,
    parameter int COLS = 70,
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter logic [2:0] DEF_FG = 3'h7,
    parameter logic [2:0] DEF_BG = 3'h0,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [7:0]    rd_ascii,
    output logic [2:0]    rd_fg,
    output logic [2:0]    rd_bg,
    output logic          rd_valid,
    input  logic          put_valid,
    output logic          put_ready,
    input  logic [7:0]    put_char,
    input  logic [2:0]    put_fg,
    input  logic [2:0]    put_bg,
    input  logic          ctl_clear,
    output logic [RW-1:0] cur_row,
    output logic [CW-1:0] cur_col
);

    localparam int CELLS = ROWS * COLS;
    localparam int AW    = $clog2(CELLS);
    localparam int RW1   = RW + 1;
    localparam logic [13:0] BLANK_CELL = {DEF_BG, DEF_FG, BLANK_CHAR};

    typedef enum logic [1:0] {IDLE, CLRLINE, CLRALL} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   cur_row_q, cur_row_d;
    logic [CW-1:0]   cur_col_q, cur_col_d;
    logic [RW-1:0]   top_q, top_d;
    logic            clr_pend_q, clr_pend_d;
    logic            rd_valid_q, rd_valid_d;
    logic [13:0]     rd_cell_q, rd_cell_d;

    logic [13:0]     mem [0:CELLS-1];
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [13:0]     wr_data;
    logic            adv;
    logic [AW-1:0]   rd_addr;
    logic            rd_in_range;

    // Logical row is rotated by the scroll offset; the sum never exceeds 2*ROWS-2.
    function automatic logic [AW-1:0] phys_addr(input logic [RW-1:0] row,
                                                 input logic [CW-1:0] col,
                                                 input logic [RW-1:0] top);
        logic [RW1-1:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        if (sum >= RW1'(ROWS))
            sum = sum - RW1'(ROWS);
        return AW'(sum[RW-1:0]) * AW'(COLS) + AW'(col);
    endfunction

    assign rd_addr     = phys_addr(rd_row, rd_col, top_q);
    assign rd_in_range = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);

    always_comb begin
        rd_valid_d = rd_en;
        rd_cell_d  = rd_cell_q;
        if (rd_en)
            rd_cell_d = rd_in_range ? mem[rd_addr] : BLANK_CELL;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        top_d      = top_q;
        clr_pend_d = clr_pend_q;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = BLANK_CELL;
        adv        = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctl_clear) begin
                    state_d = CLRALL;
                    cnt_d   = '0;
                end else if (put_valid) begin
                    if (put_char == 8'h0A) begin
                        cur_col_d = '0;
                        adv       = 1'b1;
                    end else if (put_char == 8'h08) begin
                        if (cur_col_q != '0) begin
                            cur_col_d = cur_col_q - CW'(1);
                            wr_en     = 1'b1;
                            wr_addr   = phys_addr(cur_row_q, cur_col_q - CW'(1), top_q);
                        end
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = phys_addr(cur_row_q, cur_col_q, top_q);
                        wr_data = {put_bg, put_fg, put_char};
                        if (cur_col_q == CW'(COLS - 1)) begin
                            cur_col_d = '0;
                            adv       = 1'b1;
                        end else begin
                            cur_col_d = cur_col_q + CW'(1);
                        end
                    end
                    // Advancing past the bottom row scrolls instead of moving the cursor.
                    if (adv) begin
                        if (cur_row_q == RW'(ROWS - 1)) begin
                            top_d   = (top_q == RW'(ROWS - 1)) ? '0 : top_q + RW'(1);
                            state_d = CLRLINE;
                            cnt_d   = '0;
                        end else begin
                            cur_row_d = cur_row_q + RW'(1);
                        end
                    end
                end
            end
            CLRLINE: begin
                wr_en   = 1'b1;
                wr_addr = phys_addr(RW'(ROWS - 1), cnt_q[CW-1:0], top_q);
                if (ctl_clear)
                    clr_pend_d = 1'b1;
                if (cnt_q == AW'(COLS - 1)) begin
                    cnt_d = '0;
                    if (clr_pend_q || ctl_clear) begin
                        state_d    = CLRALL;
                        clr_pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            CLRALL: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                if (cnt_q == AW'(CELLS - 1)) begin
                    cnt_d     = '0;
                    top_d     = '0;
                    cur_row_d = '0;
                    cur_col_d = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLRALL;
            cnt_q      <= '0;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            top_q      <= '0;
            clr_pend_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_cell_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            top_q      <= top_d;
            clr_pend_q <= clr_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_cell_q  <= rd_cell_d;
        end
    end

    // Cell storage carries no reset; the power-up clear initialises it.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign put_ready = (state_q == IDLE);
    assign rd_valid  = rd_valid_q;
    assign rd_ascii  = rd_cell_q[7:0];
    assign rd_fg     = rd_cell_q[10:8];
    assign rd_bg     = rd_cell_q[13:11];
    assign cur_row   = cur_row_q;
    assign cur_col   = cur_col_q;

endmodule

// File: tb/tb_vga_text_buffer.sv
// Directed bench for vga_text_buffer at ROWS=4, COLS=5.
module tb_vga_text_buffer;

    localparam int ROWS = 4;
    localparam int COLS = 5;
    localparam int RW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic [RW-1:0] rd_row = '0;
    logic [CW-1:0] rd_col = '0;
    logic [7:0]    rd_ascii;
    logic [2:0]    rd_fg;
    logic [2:0]    rd_bg;
    logic          rd_valid;
    logic          put_valid = 1'b0;
    logic          put_ready;
    logic [7:0]    put_char = '0;
    logic [2:0]    put_fg = '0;
    logic [2:0]    put_bg = '0;
    logic          ctl_clear = 1'b0;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] cur_col;

    int nchk = 0;
    int npass = 0;
    int nbusy;

    vga_text_buffer #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_ascii(rd_ascii), .rd_fg(rd_fg), .rd_bg(rd_bg), .rd_valid(rd_valid),
        .put_valid(put_valid), .put_ready(put_ready), .put_char(put_char),
        .put_fg(put_fg), .put_bg(put_bg), .ctl_clear(ctl_clear),
        .cur_row(cur_row), .cur_col(cur_col)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic chk_cur(input string tag, input int r, input int c);
        chk(tag, 32'({cur_row, cur_col}), 32'({2'(r), 3'(c)}));
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (put_ready !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
    endtask

    task automatic put(input logic [7:0] c, input logic [2:0] fg, input logic [2:0] bg);
        int n;
        count_busy(n);
        chk("put_ready_before_put", 32'(put_ready), 32'd1);
        put_valid = 1'b1;
        put_char  = c;
        put_fg    = fg;
        put_bg    = bg;
        tick;
        put_valid = 1'b0;
    endtask

    task automatic read_cell(input string tag, input int r, input int c,
                             input logic [7:0] a, input logic [2:0] fg, input logic [2:0] bg);
        rd_en  = 1'b1;
        rd_row = RW'(r);
        rd_col = CW'(c);
        tick;
        rd_en = 1'b0;
        chk($sformatf("%s(%0d,%0d)", tag, r, c),
            32'({rd_valid, rd_bg, rd_fg, rd_ascii}), 32'({1'b1, bg, fg, a}));
    endtask

    task automatic do_clear(input string tag);
        int n;
        ctl_clear = 1'b1;
        tick;
        ctl_clear = 1'b0;
        count_busy(n);
        chk(tag, 32'(n), 32'd20);
        chk_cur({tag, "_cur"}, 0, 0);
    endtask

    initial begin
        // 1. reset and power-up clear
        tick;
        tick;
        chk("reset_rd", 32'({rd_valid, rd_bg, rd_fg, rd_ascii}), 32'd0);
        chk_cur("reset_cur", 0, 0);
        chk("reset_put_ready", 32'(put_ready), 32'd0);
        rst = 1'b0;
        count_busy(nbusy);
        chk("powerup_clear_cycles", 32'(nbusy), 32'd20);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                read_cell("init_blank", r, c, 8'h20, 3'd7, 3'd0);
        tick;
        chk("rd_valid_drops", 32'(rd_valid), 32'd0);

        // 2. single put, with a same-cycle read of the written cell
        put_valid = 1'b1; put_char = 8'h41; put_fg = 3'd2; put_bg = 3'd1;
        rd_en = 1'b1; rd_row = 2'd0; rd_col = 3'd0;
        tick;
        put_valid = 1'b0; rd_en = 1'b0;
        chk("rw_same_cycle_old", 32'({rd_valid, rd_bg, rd_fg, rd_ascii}), 32'({1'b1, 3'd0, 3'd7, 8'h20}));
        chk_cur("cur_after_A", 0, 1);
        read_cell("cell_A", 0, 0, 8'h41, 3'd2, 3'd1);
        read_cell("oob_col", 0, 5, 8'h20, 3'd7, 3'd0);
        read_cell("oob_col7", 1, 7, 8'h20, 3'd7, 3'd0);

        // clear wins over a put presented in the same cycle
        put_valid = 1'b1; put_char = 8'h5A;
        do_clear("clear_over_put");
        put_valid = 1'b0;
        read_cell("after_clear", 0, 0, 8'h20, 3'd7, 3'd0);

        // 3. five puts wrap to the next row
        put(8'h48, 3'd1, 3'd0);
        put(8'h45, 3'd2, 3'd0);
        put(8'h4C, 3'd3, 3'd0);
        put(8'h4C, 3'd4, 3'd0);
        put(8'h4F, 3'd5, 3'd6);
        chk_cur("cur_after_wrap", 1, 0);
        read_cell("row0_H", 0, 0, 8'h48, 3'd1, 3'd0);
        read_cell("row0_E", 0, 1, 8'h45, 3'd2, 3'd0);
        read_cell("row0_L", 0, 2, 8'h4C, 3'd3, 3'd0);
        read_cell("row0_L", 0, 3, 8'h4C, 3'd4, 3'd0);
        read_cell("row0_O", 0, 4, 8'h4F, 3'd5, 3'd6);

        // 4. fill the screen then scroll with a newline on the bottom row
        do_clear("clear_t4");
        for (int i = 0; i < 5; i++) put(8'h61, 3'd3, 3'd4);
        for (int i = 0; i < 5; i++) put(8'h62, 3'd3, 3'd4);
        for (int i = 0; i < 5; i++) put(8'h63, 3'd3, 3'd4);
        for (int i = 0; i < 4; i++) put(8'h64, 3'd3, 3'd4);
        chk_cur("cur_before_nl", 3, 4);
        put(8'h0A, 3'd0, 3'd0);
        count_busy(nbusy);
        chk("scroll_busy_cycles", 32'(nbusy), 32'd5);
        chk_cur("cur_after_scroll", 3, 0);
        for (int c = 0; c < COLS; c++) read_cell("scr_row0", 0, c, 8'h62, 3'd3, 3'd4);
        read_cell("scr_row1", 1, 2, 8'h63, 3'd3, 3'd4);
        for (int c = 0; c < 4; c++) read_cell("scr_row2", 2, c, 8'h64, 3'd3, 3'd4);
        read_cell("scr_row2_tail", 2, 4, 8'h20, 3'd7, 3'd0);
        for (int c = 0; c < COLS; c++) read_cell("scr_row3", 3, c, 8'h20, 3'd7, 3'd0);

        // 5. backspace at column 0 and mid-line
        do_clear("clear_t5");
        put(8'h08, 3'd0, 3'd0);
        chk_cur("bs_col0_cur", 0, 0);
        chk("bs_col0_ready", 32'(put_ready), 32'd1);
        read_cell("bs_col0_cell", 0, 0, 8'h20, 3'd7, 3'd0);
        for (int i = 0; i < 7; i++) put(8'h78, 3'd1, 3'd2);
        chk_cur("cur_before_bs", 1, 2);
        put(8'h08, 3'd0, 3'd0);
        chk_cur("bs_cur", 1, 1);
        read_cell("bs_cell", 1, 1, 8'h20, 3'd7, 3'd0);
        read_cell("bs_keep", 1, 0, 8'h78, 3'd1, 3'd2);

        // 6. clear requested during a line clear, then reset mid full clear
        put(8'h0A, 3'd0, 3'd0);
        put(8'h0A, 3'd0, 3'd0);
        chk_cur("cur_row3", 3, 0);
        put(8'h0A, 3'd0, 3'd0);
        ctl_clear = 1'b1;
        tick;
        ctl_clear = 1'b0;
        count_busy(nbusy);
        chk("line_then_full_cycles", 32'(nbusy + 1), 32'd25);
        chk_cur("cur_after_pend_clear", 0, 0);
        read_cell("pend_clear_cell", 1, 0, 8'h20, 3'd7, 3'd0);

        put(8'h6B, 3'd6, 3'd1);
        ctl_clear = 1'b1;
        tick;
        ctl_clear = 1'b0;
        for (int i = 0; i < 7; i++) tick;
        chk("mid_clrall_busy", 32'(put_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk_cur("rst_mid_cur", 0, 0);
        chk("rst_mid_rd", 32'({rd_valid, rd_ascii}), 32'd0);
        tick;
        rst = 1'b0;
        count_busy(nbusy);
        chk("rst_restart_cycles", 32'(nbusy), 32'd20);
        read_cell("rst_restart_cell", 0, 0, 8'h20, 3'd7, 3'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
